// File: rtl/rsfq_dfft_driver.sv
// Serialises WIDTH-bit words, LSB first, into toggle-encoded SFQ data/clock pulses for a DFFT.
// Define RSFQ_DFFT_CHECK_EN to add the q-line checker (sfq_q, err, mismatch_cnt).
module rsfq_dfft_driver #(
    parameter int WIDTH    = 8,
    parameter int HOLD_CYC = 2,
    parameter int CHK_WIN  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             sfq_a,
    output logic             sfq_clk,
    output logic             busy
`ifdef RSFQ_DFFT_CHECK_EN
    ,
    input  logic             sfq_q,
    output logic             err,
    output logic [7:0]       mismatch_cnt
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]       HOLD_INIT = 4'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        APULSE,
        HOLD_A,
        CPULSE,
        HOLD_C
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [3:0]       hold_cnt_q, hold_cnt_d;
    logic             sfq_a_q, sfq_a_d;
    logic             sfq_clk_q, sfq_clk_d;
    logic             busy_q, busy_d;
    logic             data_ready_q, data_ready_d;
    logic             clk_edge;
    logic             win_done;

`ifdef RSFQ_DFFT_CHECK_EN
    localparam logic [3:0] WIN_INIT = 4'(CHK_WIN);

    logic       q_s1_q, q_s2_q, q_s3_q;
    logic [3:0] win_cnt_q, win_cnt_d;
    logic [1:0] tog_cnt_q, tog_cnt_d;
    logic [1:0] tog_sum;
    logic       tog;
    logic       bad;
    logic       err_q, err_d;
    logic [7:0] mis_q, mis_d;

    // The FSM may not leave HOLD_C (and shift the next bit in) before the window has closed.
    assign win_done = (win_cnt_q == 4'd0);

    always_comb begin
        win_cnt_d = win_cnt_q;
        tog_cnt_d = tog_cnt_q;
        err_d     = err_q;
        mis_d     = mis_q;
        bad       = 1'b0;
        tog       = q_s2_q ^ q_s3_q;
        tog_sum   = (tog_cnt_q == 2'd2) ? 2'd2 : (tog_cnt_q + {1'b0, tog});
        if (clk_edge) begin
            win_cnt_d = WIN_INIT;
            tog_cnt_d = 2'd0;
        end else if (win_cnt_q != 4'd0) begin
            win_cnt_d = win_cnt_q - 4'd1;
            tog_cnt_d = tog_sum;
            // sreg_q[0] is still the bit whose clock pulse opened this window.
            if (win_cnt_q == 4'd1) begin
                bad = sreg_q[0] ? (tog_sum != 2'd1) : (tog_sum != 2'd0);
            end
        end
        if (bad) begin
            err_d = 1'b1;
            if (mis_q != 8'hFF) begin
                mis_d = mis_q + 8'd1;
            end
        end
    end

    assign err          = err_q;
    assign mismatch_cnt = mis_q;
`else
    assign win_done = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        bit_cnt_d  = bit_cnt_q;
        hold_cnt_d = hold_cnt_q;
        sfq_a_d    = sfq_a_q;
        clk_edge   = 1'b0;
        case (state_q)
            IDLE: begin
                // Word is captured at acceptance so later data_in activity cannot leak in.
                if (data_valid && data_ready_q) begin
                    state_d   = LOAD;
                    sreg_d    = data_in;
                    bit_cnt_d = '0;
                end
            end
            LOAD: begin
                bit_cnt_d = '0;
                if (sreg_q[0]) begin
                    state_d = APULSE;
                    sfq_a_d = ~sfq_a_q;
                end else begin
                    state_d  = CPULSE;
                    clk_edge = 1'b1;
                end
            end
            APULSE: begin
                state_d    = HOLD_A;
                hold_cnt_d = HOLD_INIT;
            end
            HOLD_A: begin
                if (hold_cnt_q != 4'd0) begin
                    hold_cnt_d = hold_cnt_q - 4'd1;
                end else begin
                    state_d  = CPULSE;
                    clk_edge = 1'b1;
                end
            end
            CPULSE: begin
                state_d    = HOLD_C;
                hold_cnt_d = HOLD_INIT;
            end
            HOLD_C: begin
                if (hold_cnt_q != 4'd0) begin
                    hold_cnt_d = hold_cnt_q - 4'd1;
                end else if (win_done) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = IDLE;
                    end else begin
                        sreg_d    = sreg_q >> 1;
                        bit_cnt_d = bit_cnt_q + CNT_ONE;
                        if (sreg_d[0]) begin
                            state_d = APULSE;
                            sfq_a_d = ~sfq_a_q;
                        end else begin
                            state_d  = CPULSE;
                            clk_edge = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Pulses are emitted on entry to APULSE/CPULSE, so each line changes on one edge only.
        sfq_clk_d    = clk_edge ? ~sfq_clk_q : sfq_clk_q;
        busy_d       = (state_d != IDLE);
        data_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Forcing the lines low here is a level restore, not an SFQ pulse.
            state_q      <= IDLE;
            sreg_q       <= '0;
            bit_cnt_q    <= '0;
            hold_cnt_q   <= '0;
            sfq_a_q      <= 1'b0;
            sfq_clk_q    <= 1'b0;
            busy_q       <= 1'b0;
            data_ready_q <= 1'b0;
`ifdef RSFQ_DFFT_CHECK_EN
            win_cnt_q    <= '0;
            tog_cnt_q    <= '0;
            err_q        <= 1'b0;
            mis_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            bit_cnt_q    <= bit_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            sfq_a_q      <= sfq_a_d;
            sfq_clk_q    <= sfq_clk_d;
            busy_q       <= busy_d;
            data_ready_q <= data_ready_d;
`ifdef RSFQ_DFFT_CHECK_EN
            win_cnt_q    <= win_cnt_d;
            tog_cnt_q    <= tog_cnt_d;
            err_q        <= err_d;
            mis_q        <= mis_d;
`endif
        end
`ifdef RSFQ_DFFT_CHECK_EN
        q_s1_q <= sfq_q;
        q_s2_q <= q_s1_q;
        q_s3_q <= q_s2_q;
`endif
    end

    assign data_ready = data_ready_q;
    assign sfq_a      = sfq_a_q;
    assign sfq_clk    = sfq_clk_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_rsfq_dfft_driver.sv
// Bench for rsfq_dfft_driver: directed and random words against an edge-timeline reference model.
module tb_rsfq_dfft_driver;

    localparam int W    = 8;
    localparam int H    = 2;
    localparam int CW   = 4;
    localparam int GAPA = H + 1;
`ifdef RSFQ_DFFT_CHECK_EN
    localparam int GAPC = ((CW > H) ? CW : H) + 1;
`else
    localparam int GAPC = H + 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         data_valid = 1'b0;
    logic         data_ready;
    logic         sfq_a;
    logic         sfq_clk;
    logic         busy;
`ifdef RSFQ_DFFT_CHECK_EN
    logic         sfq_q_m = 1'b0;
    logic         err;
    logic [7:0]   mismatch_cnt;
    logic         q_stuck = 1'b0;
    logic         q_pend = 1'b0;
    logic         qa_p = 1'b0;
    logic         qc_p = 1'b0;
`endif

    rsfq_dfft_driver #(.WIDTH(W), .HOLD_CYC(H), .CHK_WIN(CW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .data_in(data_in),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .sfq_a(sfq_a),
        .sfq_clk(sfq_clk),
        .busy(busy)
`ifdef RSFQ_DFFT_CHECK_EN
        ,
        .sfq_q(sfq_q_m),
        .err(err),
        .mismatch_cnt(mismatch_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int   cyc;
        logic is_clk;
    } ev_t;

    ev_t  obs_q[$];
    ev_t  exp_q[$];
    int   fall_q[$];
    int   cyc = 0;
    logic rst_at_edge = 1'b0;
    logic pa = 1'b0, pc = 1'b0, pbusy = 1'b0;
    int   both_cnt = 0;
    int   rdy_bad = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic ev_t mk_ev(input int c, input logic k);
        ev_t e;
        e.cyc    = c;
        e.is_clk = k;
        return e;
    endfunction

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst_n;
    end

    // Edge monitor; level changes caused by reset are not pulses and are skipped.
    always @(negedge clk) begin
        if (rst_at_edge) begin
            if (sfq_a !== pa && sfq_clk !== pc) both_cnt <= both_cnt + 1;
            if (sfq_a !== pa) obs_q.push_back(mk_ev(cyc, 1'b0));
            if (sfq_clk !== pc) obs_q.push_back(mk_ev(cyc, 1'b1));
            if (pbusy === 1'b1 && busy === 1'b0) fall_q.push_back(cyc);
            if (data_ready !== ~busy) rdy_bad <= rdy_bad + 1;
        end
        pa    <= sfq_a;
        pc    <= sfq_clk;
        pbusy <= busy;
    end

`ifdef RSFQ_DFFT_CHECK_EN
    // Ideal DFFT: a stored data pulse toggles q on the next clock pulse.
    always @(negedge clk) begin
        if (!rst_at_edge) begin
            q_pend <= 1'b0;
        end else if (sfq_clk !== qc_p) begin
            if (q_pend && !q_stuck) sfq_q_m <= ~sfq_q_m;
            q_pend <= 1'b0;
        end else if (sfq_a !== qa_p) begin
            q_pend <= 1'b1;
        end
        qa_p <= sfq_a;
        qc_p <= sfq_clk;
    end
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference timeline: first edge one cycle after acceptance, data edge then clock edge per 1-bit.
    function automatic int add_word(input logic [W-1:0] w, input int acc);
        int t = acc + 1;
        int last = 0;
        for (int i = 0; i < W; i++) begin
            if (w[i]) begin
                exp_q.push_back(mk_ev(t, 1'b0));
                t += GAPA;
            end
            exp_q.push_back(mk_ev(t, 1'b1));
            last = t;
            t += GAPC;
        end
        return last + GAPC;
    endfunction

    task automatic compare_events(input string tag, input int base);
        int n = obs_q.size() - base;
        chk({tag, "_edge_count"}, n, exp_q.size());
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            chk({tag, "_edge_cycle"}, obs_q[base + i].cyc, exp_q[i].cyc);
            chk({tag, "_edge_line"}, obs_q[base + i].is_clk, exp_q[i].is_clk);
        end
    endtask

    task automatic count_lines(input int base, output int na, output int nc);
        na = 0;
        nc = 0;
        for (int i = base; i < obs_q.size(); i++) begin
            if (obs_q[i].is_clk) nc++;
            else na++;
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (data_ready !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk("ready_timeout", data_ready, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            step();
            n++;
        end
        chk("busy_timeout", busy, 0);
    endtask

    task automatic fall_chk(input string tag, input int idx, input int exp);
        chk(tag, (fall_q.size() > idx) ? fall_q[idx] : -1, exp);
    endtask

    // One word with junk on data_in/data_valid while busy; returns the obs base index.
    task automatic run_word(input string tag, input logic [W-1:0] w, output int base);
        int acc, fall, fb;
        base = obs_q.size();
        fb   = fall_q.size();
        exp_q.delete();
        wait_ready();
        data_in    = w;
        data_valid = 1'b1;
        acc        = cyc + 1;
        fall       = add_word(w, acc);
        step();
        while (cyc < fall - 1) begin
            data_in    = W'($urandom);
            data_valid = 1'($urandom_range(0, 1));
            step();
        end
        data_valid = 1'b0;
        wait_done();
        step();
        fall_chk({tag, "_busy_fall"}, fb, fall);
        compare_events(tag, base);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) step();
        chk("rst_sfq_a", sfq_a, 0);
        chk("rst_sfq_clk", sfq_clk, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", data_ready, 0);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", data_ready, 1);
    endtask

    initial begin
        int base, na, nc, acc1, fall1, fall2, fb, t_a3;
        repeat (3) step();
        do_reset();
        chk("post_rst_busy", busy, 0);

        run_word("w01", 8'h01, base);
        count_lines(base, na, nc);
        chk("w01_a_edges", na, 1);
        chk("w01_clk_edges", nc, 8);

        run_word("w00", 8'h00, base);
        count_lines(base, na, nc);
        chk("w00_a_edges", na, 0);
        chk("w00_clk_edges", nc, 8);

        // FF then A5 back-to-back, data_valid held, data_in scrambled during the first word.
        base = obs_q.size();
        fb   = fall_q.size();
        exp_q.delete();
        wait_ready();
        data_in    = 8'hFF;
        data_valid = 1'b1;
        acc1       = cyc + 1;
        fall1      = add_word(8'hFF, acc1);
        fall2      = add_word(8'hA5, fall1 + 1);
        step();
        while (cyc < fall1 - GAPC) begin
            data_in = W'($urandom);
            step();
        end
        data_in = 8'hA5;
        while (cyc < fall1 + 1) step();
        data_valid = 1'b0;
        data_in    = W'($urandom);
        chk("b2b_second_accepted", busy, 1);
        wait_done();
        step();
        fall_chk("b2b_fall1", fb, fall1);
        fall_chk("b2b_fall2", fb + 1, fall2);
        compare_events("b2b", base);
        count_lines(base, na, nc);
        chk("b2b_a_edges", na, 12);
        chk("b2b_clk_edges", nc, 16);

        for (int k = 0; k < 20; k++) begin
            repeat ($urandom_range(0, 3)) step();
            run_word("rnd", W'($urandom), base);
        end

        // Reset in the middle of bit 3 of FF.
        base = obs_q.size();
        exp_q.delete();
        wait_ready();
        data_in    = 8'hFF;
        data_valid = 1'b1;
        void'(add_word(8'hFF, cyc + 1));
        step();
        data_valid = 1'b0;
        t_a3 = exp_q[6].cyc;
        while (exp_q.size() > 7) void'(exp_q.pop_back());
        while (cyc < t_a3) step();
        rst_n = 1'b0;
        step();
        chk("midrst_sfq_a", sfq_a, 0);
        chk("midrst_sfq_clk", sfq_clk, 0);
        chk("midrst_busy", busy, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("midrst_ready", data_ready, 1);
        repeat (30) step();
        compare_events("midrst", base);

`ifdef RSFQ_DFFT_CHECK_EN
        do_reset();
        chk("chk_rst_cnt", mismatch_cnt, 0);
        q_stuck = 1'b0;
        run_word("chk_ideal", 8'h5A, base);
        chk("chk_ideal_err", err, 0);
        chk("chk_ideal_cnt", mismatch_cnt, 0);
        do_reset();
        q_stuck = 1'b1;
        run_word("chk_stuck", 8'h5A, base);
        chk("chk_stuck_err", err, 1);
        chk("chk_stuck_cnt", mismatch_cnt, 4);
        for (int k = 0; k < 300; k++) begin
            run_word("chk_sat", 8'hFF, base);
        end
        chk("chk_sat_cnt", mismatch_cnt, 255);
        chk("chk_sat_err", err, 1);
`endif

        chk("same_cycle_edges", both_cnt, 0);
        chk("ready_vs_busy", rdy_bad, 0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/rsfq_dfft_driver.md
RSFQ_DFFT_DRIVER -- requirements
Module: rsfq_dfft_driver

Interface
REQ-001 Parameter WIDTH, default 8: bits per data word.
REQ-002 Parameter HOLD_CYC, default 2, legal 1..15: clock cycles separating any two emitted pulse edges.
REQ-003 Parameter CHK_WIN, default 4, legal 1..15: cycles after a clock pulse in which a q toggle is accepted (check build only).
REQ-004 Port clk  input  1: single system clock; all logic on rising edge.
REQ-005 Port rst_n  input  1: reset, synchronous, active-low.
REQ-006 Port data_in  input  WIDTH: word to transmit, LSB first.
REQ-007 Port data_valid  input  1: word offered on data_in.
REQ-008 Port data_ready  output  1: block accepts a word this cycle.
REQ-009 Port sfq_a  output  1: toggle-encoded data pulse line; each level change is one SFQ pulse.
REQ-010 Port sfq_clk  output  1: toggle-encoded clock pulse line to the flip-flop under drive.
REQ-011 Port busy  output  1: high from word acceptance until the last bit's hold completes.
REQ-012 Ports sfq_q input 1, err output 1, mismatch_cnt output 8: exist only with RSFQ_DFFT_CHECK_EN.

Function
REQ-013 Word accepted on a cycle with data_valid=1 and data_ready=1; data_ready=1 only in IDLE.
REQ-014 FSM states: IDLE, LOAD, APULSE, HOLD_A, CPULSE, HOLD_C.
REQ-015 IDLE -> LOAD on acceptance; LOAD latches data_in into a shift register and clears the bit counter.
REQ-016 LOAD -> APULSE if current bit=1, else -> CPULSE.
REQ-017 APULSE inverts sfq_a for exactly one edge, then HOLD_A waits HOLD_CYC cycles, then -> CPULSE.
REQ-018 CPULSE inverts sfq_clk for exactly one edge, then HOLD_C waits HOLD_CYC cycles.
REQ-019 After HOLD_C: if bit counter = WIDTH-1 -> IDLE, else shift register right by one, increment counter, -> APULSE/CPULSE by the new bit.
REQ-020 A 1-bit produces one sfq_a edge followed by one sfq_clk edge; a 0-bit produces one sfq_clk edge only.
REQ-021 Edges on sfq_a and sfq_clk never occur in the same cycle; minimum separation HOLD_CYC+1 cycles.
REQ-022 Word latency: acceptance to final sfq_clk edge = 1 + sum over bits of (ones x (HOLD_CYC+1)) + (bit index x (HOLD_CYC+1)) cycles; no idle cycles between bits.
REQ-023 data_valid while busy is ignored; data_in changes after acceptance have no effect.
REQ-024 busy deasserts in the same cycle data_ready reasserts; back-to-back words allowed with one IDLE cycle between.
REQ-025 sfq_a and sfq_clk levels persist across words; parity, not absolute level, carries meaning.

Reset
REQ-026 On rising clk with rst_n=0: state IDLE, sfq_a=0, sfq_clk=0, busy=0, data_ready=0, shift register and counters cleared.
REQ-027 data_ready=1 from the first cycle after rst_n returns high.
REQ-028 Reset mid-word aborts the word; no further edges emitted; both lines return to 0 (a reset-induced level change is not a pulse and is documented as such).

Configuration
REQ-029 Macro RSFQ_DFFT_CHECK_EN compiles in the q-line checker; without it sfq_q, err, mismatch_cnt and their logic are absent and behaviour is otherwise identical.
REQ-030 Checker: sfq_q through a two-flop synchronizer; a q toggle = synchronized level change.
REQ-031 After each CPULSE, window of CHK_WIN cycles (overlapping HOLD_C; FSM stalls in HOLD_C until window ends if CHK_WIN > HOLD_CYC); expected exactly one toggle if bit=1, none if bit=0.
REQ-032 Any deviation increments mismatch_cnt (saturating at 255) and sets err sticky; both cleared only by reset.

Verification
REQ-033 Reset, then data_in=8'h01 valid: one sfq_a edge, HOLD_CYC+1 cycles later one sfq_clk edge, then seven sfq_clk-only edges; busy falls after last hold.
REQ-034 data_in=8'h00: exactly eight sfq_clk edges, zero sfq_a edges, spacing HOLD_CYC+1.
REQ-035 8'hFF then 8'hA5 back-to-back with data_valid held: sixteen sfq_clk edges, 8+4 sfq_a edges, data_in changes mid-word ignored.
REQ-036 rst_n low during bit 3 of 8'hFF: no edges after reset cycle, sfq_a=sfq_clk=0, data_ready=1 next cycle after release.
REQ-037 Check build, ideal toggle model on sfq_q, 8'h5A: err=0, mismatch_cnt=0; model stuck at 0: mismatch_cnt=4, err=1.
REQ-038 Check build, 300 words with stuck sfq_q and 8'hFF: mismatch_cnt saturates at 255.
